// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
interface instr_fetch_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage with integrated IF/ID register; stall, flush and branch redirect.
// Optional FETCH_HOLD_EN: parks a word acked during a stall instead of refetching it.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  instr_fetch_if.master       imem,
  output logic [31:0]         IF_ID_instr,
  output logic [31:0]         IF_ID_npc,
  output logic                IF_ID_valid
);
  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef FETCH_HOLD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_t;
  logic [XLEN-1:0] hold_buf;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1} state_t;
`endif

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            req_q;

  // Modulo-2^32 increment; wraps naturally at the top of the address space.
  assign pc_inc         = pc + PC_STEP;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_npc   <= '0;
      IF_ID_valid <= 1'b0;
`ifdef FETCH_HOLD_EN
      hold_buf    <= '0;
`endif
    end else if (branch_taken) begin
      // Redirect: any acked or parked word is dropped, IF/ID gets a bubble.
      pc          <= branch_target;
      state       <= S_REQ;
      req_q       <= 1'b1;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (flush) begin
      // PC is not advanced, so a word acked this cycle gets refetched.
      state       <= S_REQ;
      req_q       <= 1'b1;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (stall) begin
`ifdef FETCH_HOLD_EN
            if (imem.imem_ack) begin
              hold_buf <= imem.imem_rdata;
              state    <= S_HOLD;
              req_q    <= 1'b0;
            end
`endif
          end else if (imem.imem_ack) begin
            IF_ID_instr <= imem.imem_rdata;
            IF_ID_npc   <= pc_inc;
            IF_ID_valid <= 1'b1;
            pc          <= pc_inc;
          end else begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
          end
        end
`ifdef FETCH_HOLD_EN
        S_HOLD: begin
          if (!stall) begin
            IF_ID_instr <= hold_buf;
            IF_ID_npc   <= pc_inc;
            IF_ID_valid <= 1'b1;
            pc          <= pc_inc;
            state       <= S_REQ;
            req_q       <= 1'b1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
